pushbutton_conditioner: RTL

Input conditioning stage directly upstream of the 4-bit microprocessor's `pushbuttons` port. It synchronises asynchronous board buttons into the CPU clock domain and debounces each bit independently. Its `buttons_clean` output drives the CPU `IN` instruction data, and it also provides per-bit press events: one-cycle pulses and sticky flags.

---
 rtl/pushbutton_conditioner_if.sv | 29 ++
 rtl/pushbutton_conditioner.sv | 66 ++++++
 2 files changed

// File: rtl/pushbutton_conditioner_if.sv
// rtl/pushbutton_conditioner_if.sv - button inputs, clear strobe and conditioned outputs
interface pushbutton_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] buttons_raw;
    logic             clear_events;
    logic [WIDTH-1:0] buttons_clean;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] press_latched;
    logic             any_pressed;

    modport master (
        output buttons_raw,
        output clear_events,
        input  buttons_clean,
        input  press_pulse,
        input  press_latched,
        input  any_pressed
    );

    modport slave (
        input  buttons_raw,
        input  clear_events,
        output buttons_clean,
        output press_pulse,
        output press_latched,
        output any_pressed
    );
endinterface

// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - two-flop synchroniser and per-bit debounce with press events
module pushbutton_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit ACTIVE_LOW_IN   = 1'b0
) (
    input  logic                     clock,
    input  logic                     reset,
    pushbutton_conditioner_if.slave  bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] latched_q, latched_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A counter only runs while s2 disagrees with the accepted level, so it never wraps.
    always_comb begin
        clean_d = clean_q;
        pulse_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    pulse_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        // A new press on the same edge as a clear survives.
        latched_d = (latched_q & ~{WIDTH{bus.clear_events}}) | pulse_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            clean_q   <= '0;
            pulse_q   <= '0;
            latched_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= bus.buttons_raw ^ {WIDTH{ACTIVE_LOW_IN}};
            s2_q      <= s1_q;
            clean_q   <= clean_d;
            pulse_q   <= pulse_d;
            latched_q <= latched_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.buttons_clean = clean_q;
    assign bus.press_pulse   = pulse_q;
    assign bus.press_latched = latched_q;
    assign bus.any_pressed   = |latched_q;
endmodule
